// File: rtl/codec_cfg_sequencer_pkg.sv
// Shared definitions for the codec configuration sequencer: codec register
// addresses, soft-mute data words, FSM and source-select enums, and the
// helper that assembles a 24-bit I2C transaction word.
package codec_cfg_pkg;

  localparam logic [6:0] REG_LVOL  = 7'h02;
  localparam logic [6:0] REG_RVOL  = 7'h03;
  localparam logic [6:0] REG_DPATH = 7'h05;
  localparam logic [6:0] REG_RESET = 7'h0F;

  localparam logic [8:0] MUTE_ON_DATA  = 9'h00E;
  localparam logic [8:0] MUTE_OFF_DATA = 9'h006;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP
  } state_t;

  typedef enum logic [1:0] {
    SRC_BOOT,
    SRC_L,
    SRC_R,
    SRC_M
  } src_t;

  // Address byte carries R/W=0 since the codec is write-only from here.
  function automatic logic [23:0] buildTxWord(input logic [6:0] devAddr,
                                              input logic [6:0] regAddr,
                                              input logic [8:0] data);
    return {devAddr, 1'b0, regAddr, data};
  endfunction

  function automatic logic [8:0] muteData(input logic muted);
    return muted ? MUTE_ON_DATA : MUTE_OFF_DATA;
  endfunction

endpackage

// File: rtl/codec_cfg_sequencer_if.sv
// Transaction handshake between the sequencer (master) and the I2C byte
// controller (slave). tx_nack is only meaningful while tx_done is high.
interface codec_cfg_sequencer_if;
  logic        tx_req;
  logic [23:0] tx_data;
  logic        tx_done;
  logic        tx_nack;

  modport master (output tx_req, output tx_data, input tx_done, input tx_nack);
  modport slave  (input tx_req, input tx_data, output tx_done, output tx_nack);
endinterface

// File: rtl/codec_cfg_sequencer_boot_rom.sv
// Boot table: combinational map from table index to the codec register
// address and 9-bit data word. Indices past the populated entries read zero.
module codec_boot_rom
  import codec_cfg_pkg::*;
#(
  parameter int NUM_CMDS = 9,
  parameter int IDXW     = 4
) (
  input  logic [IDXW-1:0] idx_i,
  output logic [6:0]      reg_o,
  output logic [8:0]      data_o
);

  // Table lookup; reset first, datapath/unmute last so the codec comes up quiet.
  always_comb begin
    reg_o  = '0;
    data_o = '0;
    if (int'(idx_i) < NUM_CMDS) begin
      case (int'(idx_i))
        0: begin reg_o = REG_RESET; data_o = 9'h000; end
        1: begin reg_o = 7'h06;     data_o = 9'h000; end
        2: begin reg_o = 7'h08;     data_o = 9'h002; end
        3: begin reg_o = REG_LVOL;  data_o = 9'h074; end
        4: begin reg_o = REG_RVOL;  data_o = 9'h074; end
        5: begin reg_o = 7'h07;     data_o = 9'h001; end
        6: begin reg_o = 7'h09;     data_o = 9'h001; end
        7: begin reg_o = 7'h04;     data_o = 9'h016; end
        8: begin reg_o = REG_DPATH; data_o = 9'h006; end
        default: begin reg_o = '0; data_o = '0; end
      endcase
    end
  end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Codec configuration sequencer: replays the boot table to the codec over
// the I2C transaction handshake, retries NACKed writes, reports a failed
// boot, restarts on request and queues runtime left/right volume writes
// behind the boot sequence.
// Optional soft mute (register 0x05 writes on mute changes) is built when
// CODEC_SOFT_MUTE_EN is defined; the default build has no mute input.
module codec_cfg_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int         NUM_CMDS   = 9,
  parameter int         MAX_RETRY  = 3,
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         GAP_CYCLES = 4,
  localparam int        IDXW       = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
) (
  input  logic                  clk_i2c,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  vol_wr_i,
  input  logic [8:0]            vol_l_i,
  input  logic [8:0]            vol_r_i,
`ifdef CODEC_SOFT_MUTE_EN
  input  logic                  mute_i,
`endif
  codec_cfg_sequencer_if.master tx_if,
  output logic                  busy_o,
  output logic                  cfg_done_o,
  output logic                  cfg_err_o,
  output logic [IDXW-1:0]       cur_index_o
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [RW-1:0]   MAX_RETRY_W = RW'(MAX_RETRY);
  localparam logic [GW-1:0]   GAP_LAST    = GW'(GAP_CYCLES - 1);
  localparam logic [IDXW-1:0] LAST_IDX    = IDXW'(NUM_CMDS - 1);

  state_t          state_q;
  src_t            src_q;
  logic [IDXW-1:0] curIndex_q;
  logic [RW-1:0]   retryCnt_q;
  logic [GW-1:0]   gapCnt_q;
  logic            bootPending_q;
  logic            startPend_q;
  logic            resend_q;
  logic            txReq_q;
  logic [23:0]     txData_q;
  logic            busy_q;
  logic            cfgDone_q;
  logic            cfgErr_q;

  logic [8:0]      volL_q, volL_d;
  logic [8:0]      volR_q, volR_d;
  logic            pendL_q, pendL_d;
  logic            pendR_q, pendR_d;

  logic [6:0]      romReg;
  logic [8:0]      romData;
  logic [23:0]     txWord;
  logic            doneNow, ackNow, retryNow, failNow, startNow;
  logic            clrL, clrR;

`ifdef CODEC_SOFT_MUTE_EN
  logic            muteIn_q;
  logic            muteLast_q;
  logic            pendM_q, pendM_d;
  logic            clrM;
`endif

  codec_boot_rom #(
    .NUM_CMDS (NUM_CMDS),
    .IDXW     (IDXW)
  ) u_rom (
    .idx_i  (curIndex_q),
    .reg_o  (romReg),
    .data_o (romData)
  );

  // Outcome strobes for the transaction finishing this cycle.
  always_comb begin
    doneNow  = (state_q == ST_WAIT) && tx_if.tx_done;
    ackNow   = doneNow && !tx_if.tx_nack;
    retryNow = doneNow && tx_if.tx_nack && (retryCnt_q < MAX_RETRY_W);
    failNow  = doneNow && tx_if.tx_nack && !(retryCnt_q < MAX_RETRY_W);
    startNow = startPend_q || start_i;
    clrL     = (ackNow || failNow) && (src_q == SRC_L);
    clrR     = (ackNow || failNow) && (src_q == SRC_R);
  end

  // Word to send for the selected source; resends keep the previous word.
  always_comb begin
    txWord = '0;
    case (src_q)
      SRC_BOOT: txWord = buildTxWord(DEV_ADDR, romReg, romData);
      SRC_L:    txWord = buildTxWord(DEV_ADDR, REG_LVOL, volL_q);
      SRC_R:    txWord = buildTxWord(DEV_ADDR, REG_RVOL, volR_q);
`ifdef CODEC_SOFT_MUTE_EN
      SRC_M:    txWord = buildTxWord(DEV_ADDR, REG_DPATH, muteData(muteIn_q));
`endif
      default:  txWord = '0;
    endcase
  end

  // Volume shadows and pending flags; a fresh vol_wr beats a same-cycle clear.
  always_comb begin
    volL_d  = volL_q;
    volR_d  = volR_q;
    pendL_d = pendL_q;
    pendR_d = pendR_q;
    if (clrL) pendL_d = 1'b0;
    if (clrR) pendR_d = 1'b0;
    if (cfgErr_q) begin
      pendL_d = 1'b0;
      pendR_d = 1'b0;
    end else if (vol_wr_i) begin
      volL_d  = vol_l_i;
      volR_d  = vol_r_i;
      pendL_d = 1'b1;
      pendR_d = 1'b1;
    end
  end

  // Register the volume shadows and pending flags.
  always_ff @(posedge clk_i2c) begin
    if (reset) begin
      volL_q  <= '0;
      volR_q  <= '0;
      pendL_q <= 1'b0;
      pendR_q <= 1'b0;
    end else begin
      volL_q  <= volL_d;
      volR_q  <= volR_d;
      pendL_q <= pendL_d;
      pendR_q <= pendR_d;
    end
  end

`ifdef CODEC_SOFT_MUTE_EN
  // Mute-change flag; only the final mute state at issue time is sent.
  always_comb begin
    clrM    = (ackNow || failNow) && (src_q == SRC_M);
    pendM_d = pendM_q;
    if (clrM) pendM_d = 1'b0;
    if (cfgErr_q) pendM_d = 1'b0;
    else if (muteIn_q != muteLast_q) pendM_d = 1'b1;
  end

  // Register the mute input, its previous value and the mute pending flag.
  always_ff @(posedge clk_i2c) begin
    if (reset) begin
      muteIn_q   <= 1'b0;
      muteLast_q <= 1'b0;
      pendM_q    <= 1'b0;
    end else begin
      muteIn_q   <= mute_i;
      muteLast_q <= muteIn_q;
      pendM_q    <= pendM_d;
    end
  end
`endif

  // Main sequencer: pick a source, issue, wait for the controller, then gap.
  always_ff @(posedge clk_i2c) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      src_q         <= SRC_BOOT;
      curIndex_q    <= '0;
      retryCnt_q    <= '0;
      gapCnt_q      <= '0;
      bootPending_q <= 1'b1;
      startPend_q   <= 1'b0;
      resend_q      <= 1'b0;
      txReq_q       <= 1'b0;
      txData_q      <= '0;
      busy_q        <= 1'b0;
      cfgDone_q     <= 1'b0;
      cfgErr_q      <= 1'b0;
    end else begin
      if (start_i) startPend_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (startNow) begin
            startPend_q   <= 1'b0;
            bootPending_q <= 1'b1;
            curIndex_q    <= '0;
            cfgDone_q     <= 1'b0;
            cfgErr_q      <= 1'b0;
            retryCnt_q    <= '0;
            resend_q      <= 1'b0;
            src_q         <= SRC_BOOT;
            busy_q        <= 1'b1;
            state_q       <= ST_ISSUE;
          end else if (resend_q) begin
            busy_q  <= 1'b1;
            state_q <= ST_ISSUE;
          end else if (bootPending_q) begin
            src_q      <= SRC_BOOT;
            retryCnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_ISSUE;
`ifdef CODEC_SOFT_MUTE_EN
          end else if (cfgDone_q && pendM_q) begin
            src_q      <= SRC_M;
            retryCnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_ISSUE;
`endif
          end else if (cfgDone_q && pendR_q && (src_q == SRC_L)) begin
            src_q      <= SRC_R;
            retryCnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_ISSUE;
          end else if (cfgDone_q && pendL_q) begin
            src_q      <= SRC_L;
            retryCnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_ISSUE;
          end else if (cfgDone_q && pendR_q) begin
            src_q      <= SRC_R;
            retryCnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!resend_q) txData_q <= txWord;
          resend_q <= 1'b0;
          txReq_q  <= 1'b1;
          state_q  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (doneNow) begin
            txReq_q  <= 1'b0;
            gapCnt_q <= '0;
            state_q  <= ST_GAP;
            if (ackNow) begin
              retryCnt_q <= '0;
              if (src_q == SRC_BOOT) begin
                if (curIndex_q == LAST_IDX) begin
                  cfgDone_q     <= 1'b1;
                  bootPending_q <= 1'b0;
                end else begin
                  curIndex_q <= curIndex_q + 1'b1;
                end
              end
            end else if (retryNow) begin
              retryCnt_q <= retryCnt_q + 1'b1;
              resend_q   <= 1'b1;
            end else begin
              retryCnt_q <= '0;
              if (src_q == SRC_BOOT) begin
                cfgErr_q      <= 1'b1;
                bootPending_q <= 1'b0;
              end
            end
          end
        end
        ST_GAP: begin
          if (gapCnt_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            gapCnt_q <= gapCnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_if.tx_req  = txReq_q;
  assign tx_if.tx_data = txData_q;
  assign busy_o        = busy_q;
  assign cfg_done_o    = cfgDone_q;
  assign cfg_err_o     = cfgErr_q;
  assign cur_index_o   = curIndex_q;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Directed bench for codec_cfg_sequencer: acts as the I2C controller,
// checks every request word, request latency and the status outputs.
module tb_codec_cfg_sequencer;

  logic       clk_i2c = 1'b0;
  logic       reset;
  logic       start_i;
  logic       vol_wr_i;
  logic [8:0] vol_l_i;
  logic [8:0] vol_r_i;
`ifdef CODEC_SOFT_MUTE_EN
  logic       mute_i;
`endif
  logic       busy_o;
  logic       cfg_done_o;
  logic       cfg_err_o;
  logic [3:0] cur_index_o;

  int checkCount   = 0;
  int errorCount   = 0;
  int cyc          = 0;
  int lastDoneEdge = 0;
  int lastRiseEdge = 0;
  int relEdge      = 0;

  // Hand-derived words: 8'h34 address byte, then {reg[6:0], data[8:0]}.
  logic [23:0] bootWord [9] = '{24'h341E00, 24'h340C00, 24'h341002,
                                24'h340474, 24'h340674, 24'h340E01,
                                24'h341201, 24'h340816, 24'h340A06};

  codec_cfg_sequencer_if txIf();

  codec_cfg_sequencer #(
    .NUM_CMDS   (9),
    .MAX_RETRY  (3),
    .DEV_ADDR   (7'h1A),
    .GAP_CYCLES (4)
  ) dut (
    .clk_i2c     (clk_i2c),
    .reset       (reset),
    .start_i     (start_i),
    .vol_wr_i    (vol_wr_i),
    .vol_l_i     (vol_l_i),
    .vol_r_i     (vol_r_i),
`ifdef CODEC_SOFT_MUTE_EN
    .mute_i      (mute_i),
`endif
    .tx_if       (txIf),
    .busy_o      (busy_o),
    .cfg_done_o  (cfg_done_o),
    .cfg_err_o   (cfg_err_o),
    .cur_index_o (cur_index_o)
  );

  always #5 clk_i2c = ~clk_i2c;

  always @(posedge clk_i2c) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit doStart, input bit doVol,
                               input logic [8:0] vl, input logic [8:0] vr);
    start_i  = doStart;
    vol_wr_i = doVol;
    if (doVol) begin
      vol_l_i = vl;
      vol_r_i = vr;
    end
    @(negedge clk_i2c);
    start_i  = 1'b0;
    vol_wr_i = 1'b0;
  endtask

  task automatic waitReq(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_i2c);
      if (txIf.tx_req === 1'b1) seen = 1'b1;
    end
    if (seen) lastRiseEdge = cyc;
  endtask

  task automatic expectNoReq(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk_i2c);
      if (txIf.tx_req !== 1'b0) seen = 1'b1;
    end
    checkOutput(tag, 32'(seen), 32'd0);
  endtask

  // Waits for a request, checks it, then answers with one tx_done pulse.
  task automatic serveWrite(input string tag, input logic [23:0] expData,
                            input int expGap, input bit nack,
                            input bit volPulse, input logic [8:0] vl,
                            input logic [8:0] vr, input bit startPulse);
    bit seen;
    waitReq(60, seen);
    checkOutput({tag, " req"}, 32'(seen), 32'd1);
    if (!seen) return;
    checkOutput({tag, " data"}, 32'(txIf.tx_data), 32'(expData));
    checkOutput({tag, " busy"}, 32'(busy_o), 32'd1);
    if (expGap >= 0)
      checkOutput({tag, " gap"}, 32'(lastRiseEdge - lastDoneEdge), 32'(expGap));
    @(negedge clk_i2c);
    if (startPulse) begin
      start_i = 1'b1;
      @(negedge clk_i2c);
      start_i = 1'b0;
    end
    txIf.tx_done = 1'b1;
    txIf.tx_nack = nack;
    if (volPulse) begin
      vol_wr_i = 1'b1;
      vol_l_i  = vl;
      vol_r_i  = vr;
    end
    @(negedge clk_i2c);
    lastDoneEdge = cyc;
    txIf.tx_done = 1'b0;
    txIf.tx_nack = 1'b0;
    vol_wr_i     = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    start_i      = 1'b0;
    vol_wr_i     = 1'b0;
    vol_l_i      = '0;
    vol_r_i      = '0;
`ifdef CODEC_SOFT_MUTE_EN
    mute_i       = 1'b0;
`endif
    txIf.tx_done = 1'b0;
    txIf.tx_nack = 1'b0;
    repeat (3) @(negedge clk_i2c);

    $display("[TB] reset values");
    checkOutput("rst tx_req", 32'(txIf.tx_req), 32'd0);
    checkOutput("rst tx_data", 32'(txIf.tx_data), 32'd0);
    checkOutput("rst busy", 32'(busy_o), 32'd0);
    checkOutput("rst cfg_done", 32'(cfg_done_o), 32'd0);
    checkOutput("rst cfg_err", 32'(cfg_err_o), 32'd0);
    checkOutput("rst cur_index", 32'(cur_index_o), 32'd0);
    reset   = 1'b0;
    relEdge = cyc;

    $display("[TB] boot with all writes acknowledged");
    serveWrite("t1 idx0", bootWord[0], -1, 1'b0, 1'b0, 9'h0, 9'h0, 1'b0);
    checkOutput("t1 first latency", 32'(lastRiseEdge - relEdge), 32'd2);
    for (int i = 1; i < 9; i++) begin
      if (i == 8) checkOutput("t1 done before last", 32'(cfg_done_o), 32'd0);
      serveWrite($sformatf("t1 idx%0d", i), bootWord[i], 6, 1'b0, 1'b0, 9'h0, 9'h0, 1'b0);
    end
    checkOutput("t1 cfg_done", 32'(cfg_done_o), 32'd1);
    checkOutput("t1 cfg_err", 32'(cfg_err_o), 32'd0);
    expectNoReq("t1 idle after boot", 20);
    checkOutput("t1 busy idle", 32'(busy_o), 32'd0);

    $display("[TB] index 3 NACKed twice then acknowledged");
    applyStimulus(1'b1, 1'b0, 9'h0, 9'h0);
    serveWrite("t2 idx0", bootWord[0], -1, 1'b0, 1'b0, 9'h0, 9'h0, 1'b0);
    checkOutput("t2 done cleared", 32'(cfg_done_o), 32'd0);
    for (int i = 1; i < 3; i++)
      serveWrite($sformatf("t2 idx%0d", i), bootWord[i], 6, 1'b0, 1'b0, 9'h0, 9'h0, 1'b0);
    serveWrite("t2 idx3 try0", bootWord[3], 6, 1'b1, 1'b0, 9'h0, 9'h0, 1'b0);
    serveWrite("t2 idx3 try1", bootWord[3], 6, 1'b1, 1'b0, 9'h0, 9'h0, 1'b0);
    serveWrite("t2 idx3 try2", bootWord[3], 6, 1'b0, 1'b0, 9'h0, 9'h0, 1'b0);
    for (int i = 4; i < 9; i++)
      serveWrite($sformatf("t2 idx%0d", i), bootWord[i], 6, 1'b0, 1'b0, 9'h0, 9'h0, 1'b0);
    checkOutput("t2 cfg_done", 32'(cfg_done_o), 32'd1);
    checkOutput("t2 cfg_err", 32'(cfg_err_o), 32'd0);
    expectNoReq("t2 idle", 12);

    $display("[TB] index 2 NACKed on every attempt");
    applyStimulus(1'b1, 1'b0, 9'h0, 9'h0);
    serveWrite("t3 idx0", bootWord[0], -1, 1'b0, 1'b0, 9'h0, 9'h0, 1'b0);
    serveWrite("t3 idx1", bootWord[1], 6, 1'b0, 1'b0, 9'h0, 9'h0, 1'b0);
    for (int a = 0; a < 4; a++)
      serveWrite($sformatf("t3 idx2 try%0d", a), bootWord[2], 6, 1'b1, 1'b0, 9'h0, 9'h0, 1'b0);
    checkOutput("t3 cfg_err", 32'(cfg_err_o), 32'd1);
    checkOutput("t3 cur_index", 32'(cur_index_o), 32'd2);
    checkOutput("t3 cfg_done", 32'(cfg_done_o), 32'd0);
    expectNoReq("t3 no fifth attempt", 20);

    $display("[TB] restart after error, volume write at index 4");
    applyStimulus(1'b1, 1'b0, 9'h0, 9'h0);
    serveWrite("t4 idx0", bootWord[0], -1, 1'b0, 1'b0, 9'h0, 9'h0, 1'b0);
    checkOutput("t4 err cleared", 32'(cfg_err_o), 32'd0);
    for (int i = 1; i < 9; i++) begin
      serveWrite($sformatf("t4 idx%0d", i), bootWord[i], 6, 1'b0, 1'b0, 9'h0, 9'h0, 1'b0);
      if (i == 3) applyStimulus(1'b0, 1'b1, 9'h079, 9'h079);
    end
    checkOutput("t4 cfg_done", 32'(cfg_done_o), 32'd1);
    serveWrite("t4 vol L", 24'h340479, 6, 1'b0, 1'b0, 9'h0, 9'h0, 1'b0);
    serveWrite("t4 vol R", 24'h340679, 6, 1'b0, 1'b0, 9'h0, 9'h0, 1'b0);
    expectNoReq("t4 idle after volume", 20);

    $display("[TB] volume write during the left write completion");
    applyStimulus(1'b0, 1'b1, 9'h050, 9'h051);
    serveWrite("t5 L old", 24'h340450, -1, 1'b0, 1'b1, 9'h0A0, 9'h0A1, 1'b0);
    serveWrite("t5 R new", 24'h3406A1, 6, 1'b0, 1'b0, 9'h0, 9'h0, 1'b0);
    serveWrite("t5 L new", 24'h3404A0, 6, 1'b0, 1'b0, 9'h0, 9'h0, 1'b0);
    expectNoReq("t5 idle", 20);

    $display("[TB] start during WAIT at index 5");
    applyStimulus(1'b1, 1'b0, 9'h0, 9'h0);
    serveWrite("t6 idx0", bootWord[0], -1, 1'b0, 1'b0, 9'h0, 9'h0, 1'b0);
    for (int i = 1; i < 5; i++)
      serveWrite($sformatf("t6 idx%0d", i), bootWord[i], 6, 1'b0, 1'b0, 9'h0, 9'h0, 1'b0);
    serveWrite("t6 idx5", bootWord[5], 6, 1'b0, 1'b0, 9'h0, 9'h0, 1'b1);
    serveWrite("t6 restart idx0", bootWord[0], 6, 1'b0, 1'b0, 9'h0, 9'h0, 1'b0);
    checkOutput("t6 cur_index", 32'(cur_index_o), 32'd1);
    checkOutput("t6 cfg_done", 32'(cfg_done_o), 32'd0);

    $display("[TB] reset during a transaction");
    begin
      bit seen;
      waitReq(60, seen);
      checkOutput("t7 req before reset", 32'(seen), 32'd1);
    end
    reset = 1'b1;
    @(negedge clk_i2c);
    checkOutput("t7 tx_req", 32'(txIf.tx_req), 32'd0);
    checkOutput("t7 tx_data", 32'(txIf.tx_data), 32'd0);
    checkOutput("t7 busy", 32'(busy_o), 32'd0);
    checkOutput("t7 cur_index", 32'(cur_index_o), 32'd0);
    reset   = 1'b0;
    relEdge = cyc;
    serveWrite("t7 reboot idx0", bootWord[0], -1, 1'b0, 1'b0, 9'h0, 9'h0, 1'b0);
    checkOutput("t7 latency", 32'(lastRiseEdge - relEdge), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
